// File: rtl/telem_ft_framer_if.sv
// FT600 bridge user-side write port: one 16-bit word per transfer,
// a transfer happens when ui_din_valid=1 and ui_din_full=0.
interface telem_ft_framer_if;
  logic [15:0] ui_din;
  logic [1:0]  ui_din_be;
  logic        ui_din_valid;
  logic        ui_din_full;

  modport master (
    output ui_din,
    output ui_din_be,
    output ui_din_valid,
    input  ui_din_full
  );

  modport slave (
    input  ui_din,
    input  ui_din_be,
    input  ui_din_valid,
    output ui_din_full
  );
endinterface

// File: rtl/telem_ft_framer.sv
// Buffers 88-bit telemetry packets in a small FIFO and frames each one into
// eight 16-bit words for the FT600 write port, honouring ui_din_full backpressure.
module telem_ft_framer #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] MAGIC      = 16'hDEC0,
  parameter logic [7:0]  MARKER     = 8'h7C
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [87:0] pkt_data,
  input  logic        pkt_valid,
  input  logic        enable,
  telem_ft_framer_if.master ft,
  output logic [15:0] pkt_seq,
  output logic [15:0] drop_cnt,
  output logic        overflow,
  output logic        busy
);

  localparam int             AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]    DEPTH   = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]    CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0]  PTR_ONE = AW'(1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t        state, next_state;
  logic [103:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [103:0]  frame_q;
  logic [103:0]  head;
  logic [15:0]   din_q;
  logic          valid_q;
  logic [2:0]    idx;
  logic          full, empty, push, drop, xfer, last;
  logic          pop, advance, finish;

  assign full  = (count == DEPTH);
  assign empty = (count == '0);
  assign push  = pkt_valid & enable & ~full;
  assign drop  = pkt_valid & enable & full;
  assign xfer  = valid_q & ~ft.ui_din_full;
  assign last  = (idx == 3'd7);
  assign head  = mem[rd_ptr];

  assign ft.ui_din       = din_q;
  assign ft.ui_din_valid = valid_q;
  assign ft.ui_din_be    = valid_q ? 2'b11 : 2'b00;
  assign busy            = (state != IDLE) || !empty;

  // Entry layout is {seq, data}; seq sits in the top 16 bits so word 7 is f[103:88].
  function automatic logic [15:0] word_sel(input logic [103:0] f, input logic [2:0] i);
    word_sel = 16'h0000;
    case (i)
      3'd0: word_sel = f[15:0];
      3'd1: word_sel = f[31:16];
      3'd2: word_sel = f[47:32];
      3'd3: word_sel = f[63:48];
      3'd4: word_sel = f[79:64];
      3'd5: word_sel = {MARKER, f[87:80]};
      3'd6: word_sel = MAGIC;
      3'd7: word_sel = f[103:88];
      default: word_sel = 16'h0000;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst_n && push) mem[wr_ptr] <= {pkt_seq, pkt_data};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pkt_seq  <= 16'h0000;
      drop_cnt <= 16'h0000;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + PTR_ONE;
        pkt_seq <= pkt_seq + 16'd1;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!empty) next_state = SEND;
      SEND:    if (xfer && last && empty) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Popping on the last transfer of a frame chains the next frame without a bubble.
  always_comb begin
    pop     = 1'b0;
    advance = 1'b0;
    finish  = 1'b0;
    case (state)
      IDLE: pop = !empty;
      SEND: begin
        if (xfer) begin
          if (!last)      advance = 1'b1;
          else if (!empty) pop    = 1'b1;
          else            finish  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_q <= '0;
      din_q   <= 16'h0000;
      valid_q <= 1'b0;
      idx     <= 3'd0;
    end else if (pop) begin
      frame_q <= head;
      din_q   <= head[15:0];
      valid_q <= 1'b1;
      idx     <= 3'd0;
    end else if (advance) begin
      idx   <= idx + 3'd1;
      din_q <= word_sel(frame_q, idx + 3'd1);
    end else if (finish) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_telem_ft_framer.sv
// Table-driven bench for telem_ft_framer: each record drives one clock cycle
// and lists the outputs expected just after that edge.
module tb_telem_ft_framer;

  localparam logic [87:0] D = 88'h0A_0908_0706_0504_0302_0100;

  typedef struct {
    logic        rst_n;
    logic        en;
    logic        pv;
    logic        full;
    logic        exp_valid;
    logic [15:0] exp_din;
    logic        chk_stat;
    logic [15:0] exp_seq;
    logic [15:0] exp_drop;
    logic        exp_ovf;
    logic        exp_busy;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [87:0] pkt_data;
  logic        pkt_valid;
  logic        enable;
  logic [15:0] pkt_seq;
  logic [15:0] drop_cnt;
  logic        overflow;
  logic        busy;

  telem_ft_framer_if ft ();

  telem_ft_framer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pkt_data  (pkt_data),
    .pkt_valid (pkt_valid),
    .enable    (enable),
    .ft        (ft.master),
    .pkt_seq   (pkt_seq),
    .drop_cnt  (drop_cnt),
    .overflow  (overflow),
    .busy      (busy)
  );

  int   checks   = 0;
  int   failures = 0;
  vec_t tbl[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] fw(input logic [87:0] d, input logic [15:0] s, input int i);
    logic [15:0] w;
    case (i)
      0: w = d[15:0];
      1: w = d[31:16];
      2: w = d[47:32];
      3: w = d[63:48];
      4: w = d[79:64];
      5: w = {8'h7C, d[87:80]};
      6: w = 16'hDEC0;
      default: w = s;
    endcase
    return w;
  endfunction

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic r, input logic en, input logic pv, input logic full,
                         input logic ev, input logic [15:0] ed);
    vec_t v;
    v.rst_n = r; v.en = en; v.pv = pv; v.full = full;
    v.exp_valid = ev; v.exp_din = ed;
    v.chk_stat = 1'b0; v.exp_seq = 16'h0; v.exp_drop = 16'h0; v.exp_ovf = 1'b0; v.exp_busy = 1'b0;
    tbl.push_back(v);
  endtask

  task automatic add_stat(input logic [15:0] s, input logic [15:0] dr, input logic o, input logic b);
    vec_t v;
    v = tbl[tbl.size()-1];
    v.chk_stat = 1'b1; v.exp_seq = s; v.exp_drop = dr; v.exp_ovf = o; v.exp_busy = b;
    tbl[tbl.size()-1] = v;
  endtask

  task automatic apply_stimulus(input vec_t v);
    rst_n          = v.rst_n;
    enable         = v.en;
    pkt_valid      = v.pv;
    ft.ui_din_full = v.full;
    @(posedge clk);
    #1;
  endtask

  task automatic run_table(input string tname);
    for (int i = 0; i < tbl.size(); i++) begin
      apply_stimulus(tbl[i]);
      check_output($sformatf("%s[%0d].valid", tname, i), {15'd0, ft.ui_din_valid}, {15'd0, tbl[i].exp_valid});
      if (tbl[i].exp_valid) begin
        check_output($sformatf("%s[%0d].din", tname, i), ft.ui_din, tbl[i].exp_din);
        check_output($sformatf("%s[%0d].be", tname, i), {14'd0, ft.ui_din_be}, 16'h0003);
      end
      if (tbl[i].chk_stat) begin
        check_output($sformatf("%s[%0d].pkt_seq", tname, i), pkt_seq, tbl[i].exp_seq);
        check_output($sformatf("%s[%0d].drop_cnt", tname, i), drop_cnt, tbl[i].exp_drop);
        check_output($sformatf("%s[%0d].overflow", tname, i), {15'd0, overflow}, {15'd0, tbl[i].exp_ovf});
        check_output($sformatf("%s[%0d].busy", tname, i), {15'd0, busy}, {15'd0, tbl[i].exp_busy});
      end
    end
    tbl.delete();
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    enable         = 1'b1;
    pkt_valid      = 1'b0;
    ft.ui_din_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    pkt_data = D;
    do_reset();
    check_output("reset.din", ft.ui_din, 16'h0000);
    check_output("reset.valid", {15'd0, ft.ui_din_valid}, 16'h0000);
    check_output("reset.be", {14'd0, ft.ui_din_be}, 16'h0000);
    check_output("reset.pkt_seq", pkt_seq, 16'h0000);
    check_output("reset.drop_cnt", drop_cnt, 16'h0000);
    check_output("reset.overflow", {15'd0, overflow}, 16'h0000);
    check_output("reset.busy", {15'd0, busy}, 16'h0000);

    // Single frame, first word two edges after the strobe.
    for (int k = 0; k < 10; k++)
      add_vec(1, 1, k == 0, 0, (k >= 1 && k <= 8), fw(D, 16'd0, k - 1));
    tbl[0].chk_stat = 1'b1; tbl[0].exp_seq = 16'd1; tbl[0].exp_busy = 1'b1;
    add_stat(16'd1, 16'd0, 0, 0);
    run_table("t1_single");

    // Backpressure for 5 cycles while w3 is presented.
    do_reset();
    for (int k = 0; k < 15; k++) begin
      int wi;
      wi = (k <= 4) ? k - 1 : (k <= 9) ? 3 : k - 6;
      add_vec(1, 1, k == 0, (k >= 5 && k <= 9), (k >= 1 && k <= 13), fw(D, 16'd0, wi));
    end
    add_stat(16'd1, 16'd0, 0, 0);
    run_table("t2_full");

    // Three packets 8 cycles apart stream as 24 contiguous words.
    do_reset();
    for (int k = 0; k < 26; k++)
      add_vec(1, 1, (k == 0 || k == 8 || k == 16), 0, (k >= 1 && k <= 24),
              fw(D, 16'((k - 1) / 8), (k - 1) % 8));
    add_stat(16'd3, 16'd0, 0, 0);
    run_table("t3_stream");

    // Frame register holds pkt 0 under full; 6 more strobes: 4 buffered, 2 dropped.
    do_reset();
    for (int k = 0; k < 48; k++) begin
      int g;
      g = (k <= 7) ? 0 : k - 7;
      add_vec(1, 1, (k == 0 || (k >= 2 && k <= 7)), (k <= 7), (k >= 1 && k <= 46),
              fw(D, 16'(g / 8), g % 8));
      if (k == 7)  add_stat(16'd5, 16'd2, 1, 1);
      if (k == 47) add_stat(16'd5, 16'd2, 1, 0);
    end
    run_table("t4_drop");

    // Strobes while disabled are ignored and not counted as drops.
    do_reset();
    for (int k = 0; k < 13; k++) begin
      add_vec(1, (k >= 3), (k <= 3), 0, (k >= 4 && k <= 11), fw(D, 16'd0, k - 4));
      if (k == 2)  add_stat(16'd0, 16'd0, 0, 0);
      if (k == 12) add_stat(16'd1, 16'd0, 0, 0);
    end
    run_table("t5_enable");

    // Reset during w4 with two packets queued abandons everything.
    do_reset();
    for (int k = 0; k < 21; k++) begin
      add_vec((k != 6), 1, (k <= 2), 0, (k >= 1 && k <= 5), fw(D, 16'd0, k - 1));
      if (k == 5) add_stat(16'd3, 16'd0, 0, 1);
      if (k >= 6) add_stat(16'd0, 16'd0, 0, 0);
    end
    run_table("t6_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
